instr_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 64-word instruction ROM. It owns the program counter and drives the ROM address. It captures each returned 32-bit word into a single-entry output register and hands it to decode over a valid/ready handshake. It also handles start, branch/jump redirect with flush, and halt-on-sentinel.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/instr_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch path: state encoding and the
// default geometry/sentinel also used by the ROM and decode stages.
package ifetch_pkg;

    localparam int DEF_PC_W = 6;
    localparam int DEF_INSTR_W = 32;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, fetches from the ROM into a single
// output slot handed to decode over valid/ready, with redirect and halt handling.
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               if_valid_o,
    input  logic               if_ready_i,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [PC_W-1:0]    if_pc_o,
    output logic               busy_o,
    output logic               halted_o
);

    state_e             r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_out;

    logic               w_take;
    logic               w_free;
    logic               w_is_halt;
    logic [PC_W-1:0]    w_pc_next;

    assign w_take    = r_valid & if_ready_i;
    assign w_free    = ~r_valid | if_ready_i;
    assign w_is_halt = (imem_data_i == HALT_WORD);
    assign w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // Sequencer: state, pc and the output slot advance together on each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= {PC_W{1'b0}};
            r_valid  <= 1'b0;
            r_instr  <= {INSTR_W{1'b0}};
            r_pc_out <= {PC_W{1'b0}};
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    // A leftover slot still drains to decode while stopped.
                    if (w_take) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= r_valid;
                    end
                    if (start_i) begin
                        r_pc    <= {PC_W{1'b0}};
                        r_state <= RUN;
                    end else begin
                        r_pc    <= r_pc;
                        r_state <= r_state;
                    end
                end
                RUN: begin
                    if (redirect_i) begin
                        r_pc    <= redirect_pc_i;
                        r_valid <= 1'b0;
                    end else if (w_free) begin
                        if (w_is_halt) begin
                            // The sentinel is never presented; pc parks on it.
                            r_state <= HALTED;
                            r_valid <= 1'b0;
                        end else begin
                            r_instr  <= imem_data_i;
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_pc     <= w_pc_next;
                        end
                    end else begin
                        r_valid <= r_valid;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr_o = r_pc;
    assign if_valid_o  = r_valid;
    assign if_instr_o  = r_instr;
    assign if_pc_o     = r_pc_out;
    assign busy_o      = (r_state == RUN);
    assign halted_o    = (r_state == HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: ROM model, cycle reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
module tb_instr_fetch_ctrl;

    localparam int PC_W = 6;
    localparam int INSTR_W = 32;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_HALTED = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic               redirect_i = 1'b0;
    logic [PC_W-1:0]    redirect_pc_i = '0;
    logic [PC_W-1:0]    imem_addr_o;
    logic [INSTR_W-1:0] imem_data_i;
    logic               if_valid_o;
    logic               if_ready_i = 1'b0;
    logic [INSTR_W-1:0] if_instr_o;
    logic [PC_W-1:0]    if_pc_o;
    logic               busy_o;
    logic               halted_o;

    logic [31:0] rom [0:63];
    assign imem_data_i = rom[imem_addr_o];

    instr_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o),
        .imem_data_i(imem_data_i), .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
        .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .busy_o(busy_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_st;
    int m_pc;
    bit m_v;
    logic [31:0] m_i;
    int m_p;
    bit take;
    int dut_pcs[$];
    logic [31:0] dut_ins[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what fetch must do per edge, plus a log of DUT transfers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_pc = 0; m_v = 1'b0; m_i = 32'd0; m_p = 0;
        end else begin
            if (if_valid_o && if_ready_i && !(busy_o && redirect_i)) begin
                dut_pcs.push_back(int'(if_pc_o));
                dut_ins.push_back(if_instr_o);
            end
            take = m_v && if_ready_i;
            if (m_st != M_RUN) begin
                if (take) m_v = 1'b0;
                if (start_i) begin
                    m_st = M_RUN;
                    m_pc = 0;
                end
            end else if (redirect_i) begin
                m_pc = int'(redirect_pc_i);
                m_v = 1'b0;
            end else if (!m_v || take) begin
                if (rom[m_pc] == HALT) begin
                    m_st = M_HALTED;
                    m_v = 1'b0;
                end else begin
                    m_i = rom[m_pc];
                    m_p = m_pc;
                    m_v = 1'b1;
                    m_pc = (m_pc + 1) % 64;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("addr", 32'(imem_addr_o), 32'(m_pc));
            check("valid", 32'(if_valid_o), 32'(m_v));
            check("instr", if_instr_o, m_i);
            check("if_pc", 32'(if_pc_o), 32'(m_p));
            check("busy", 32'(busy_o), 32'(m_st == M_RUN));
            check("halted", 32'(halted_o), 32'(m_st == M_HALTED));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 64; i++) rom[i] = $urandom & 32'h7FFF_FFFF;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted_o && n < budget) begin
            tick();
            n++;
        end
        check("halt_reached", 32'(halted_o), 32'd1);
    endtask

    task automatic check_stream(input string name, input int exp_pcs[$]);
        check({name, "_len"}, 32'(dut_pcs.size()), 32'(exp_pcs.size()));
        for (int i = 0; i < exp_pcs.size() && i < dut_pcs.size(); i++) begin
            check({name, "_pc"}, 32'(dut_pcs[i]), 32'(exp_pcs[i]));
            check({name, "_ins"}, dut_ins[i], rom[exp_pcs[i]]);
        end
    endtask

    initial begin
        fill_rom();
        rom[0] = 32'hA000_0001; rom[1] = 32'hB000_0002;
        rom[2] = 32'hC000_0003; rom[3] = 32'hD000_0004; rom[4] = HALT;
        chk_en = 1'b1;
        repeat (2) tick();
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_addr", 32'(imem_addr_o), 32'd0);
        check("rst_instr", if_instr_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if_ready_i = 1'b1;

        // Straight-line run
        dut_pcs.delete(); dut_ins.delete();
        pulse_start();
        tick();
        check("sl_first_valid", 32'(if_valid_o), 32'd1);
        check("sl_first_pc", 32'(if_pc_o), 32'd0);
        check("sl_first_instr", if_instr_o, 32'hA000_0001);
        repeat (3) tick();
        check("sl_d_instr", if_instr_o, 32'hD000_0004);
        check("sl_d_halted", 32'(halted_o), 32'd0);
        tick();
        check("sl_halted", 32'(halted_o), 32'd1);
        check("sl_addr4", 32'(imem_addr_o), 32'd4);
        check("sl_model_pc", 32'(m_pc), 32'd4);
        check_stream("sl", '{0, 1, 2, 3});
        repeat (2) tick();
        check("sl_addr_hold", 32'(imem_addr_o), 32'd4);

        // Backpressure, restarting from HALTED
        dut_pcs.delete(); dut_ins.delete();
        pulse_start();
        tick();
        check("bp_a_valid", 32'(if_valid_o), 32'd1);
        @(negedge clk);
        if_ready_i = 1'b0;
        repeat (3) begin
            tick();
            check("bp_hold_pc", 32'(if_pc_o), 32'd0);
            check("bp_hold_instr", if_instr_o, 32'hA000_0001);
            check("bp_hold_addr", 32'(imem_addr_o), 32'd1);
        end
        @(negedge clk);
        if_ready_i = 1'b1;
        tick();
        check("bp_b_instr", if_instr_o, 32'hB000_0002);
        wait_halt(10);
        check_stream("bp", '{0, 1, 2, 3});

        // Redirect flushes B
        for (int i = 20; i < 24; i++) rom[i] = 32'h2000_0000 + 32'(i);
        rom[24] = HALT;
        dut_pcs.delete(); dut_ins.delete();
        pulse_start();
        tick();
        tick();
        check("rd_b_pc", 32'(if_pc_o), 32'd1);
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 6'd20;
        tick();
        check("rd_bubble", 32'(if_valid_o), 32'd0);
        check("rd_addr", 32'(imem_addr_o), 32'd20);
        @(negedge clk);
        redirect_i = 1'b0;
        tick();
        check("rd_tgt_pc", 32'(if_pc_o), 32'd20);
        check("rd_tgt_instr", if_instr_o, 32'h2000_0014);
        wait_halt(10);
        check_stream("rd", '{0, 20, 21, 22, 23});

        // Wrap 62 -> 63 -> 0, then restart from HALTED
        rom[62] = 32'h6200_0000; rom[63] = 32'h6300_0000; rom[1] = HALT;
        dut_pcs.delete(); dut_ins.delete();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 6'd62;
        @(negedge clk);
        redirect_i = 1'b0;
        wait_halt(10);
        check_stream("wrap", '{62, 63, 0});
        pulse_start();
        tick();
        check("restart_pc", 32'(if_pc_o), 32'd0);
        check("restart_valid", 32'(if_valid_o), 32'd1);
        wait_halt(10);

        // Halt word behind a stalled slot
        rom[1] = 32'hB000_0002; rom[3] = HALT;
        dut_pcs.delete(); dut_ins.delete();
        pulse_start();
        repeat (3) tick();
        check("hp_c_pc", 32'(if_pc_o), 32'd2);
        @(negedge clk);
        if_ready_i = 1'b0;
        repeat (2) begin
            tick();
            check("hp_c_valid", 32'(if_valid_o), 32'd1);
            check("hp_c_instr", if_instr_o, 32'hC000_0003);
            check("hp_stall_halted", 32'(halted_o), 32'd0);
        end
        @(negedge clk);
        if_ready_i = 1'b1;
        tick();
        check("hp_halted", 32'(halted_o), 32'd1);
        check("hp_drop", 32'(if_valid_o), 32'd0);
        check_stream("hp", '{0, 1, 2});

        // Async reset in the middle of a run
        fill_rom();
        pulse_start();
        repeat (3) tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(if_valid_o), 32'd0);
        check("ar_addr", 32'(imem_addr_o), 32'd0);
        check("ar_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        start_i = 1'b1;
        repeat (3) begin
            tick();
            check("ar_start_ignored", 32'(busy_o), 32'd0);
        end
        @(negedge clk);
        start_i = 1'b0;
        rst_n = 1'b1;
        tick();
        check("ar_idle", 32'(busy_o), 32'd0);

        // Randomized soak
        for (int i = 0; i < 64; i++)
            rom[i] = (($urandom % 16) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if_ready_i = (($urandom % 4) != 0);
            redirect_i = (($urandom % 10) == 0);
            redirect_pc_i = 6'($urandom);
            start_i = (($urandom % 8) == 0);
        end
        @(negedge clk);
        start_i = 1'b0;
        redirect_i = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
